dti_req_arbiter: RTL and testbench
==================================

// Module: dti_req_arbiter
// PURPOSE
// - Packet-level arbiter sharing one custom-NoC request channel between PORT_NUM DTI request sources
//   (partial-reset adapters / TBU ports); sits between the adapters' custom-side req ports and the NoC.
// - QoS-aware round-robin with starvation guard; never interleaves beats of different packets.
// - hold/ack interface lets a reset sequencer drain the channel at a packet boundary.
// PARAMETERS
// - PORT_NUM     4    number of requesting ports (2..16)
// - PLD_W        90   payload width ({tdata[79:0], tkeep[9:0]})
// - ID_W         6    srcid/tgtid width
// - STARVE_LIMIT 8    consecutive qos=1 packet grants after which a waiting qos=0 port is forced (1..255)
// PORTS
// - clk          in   1                 clock
// - rst_n        in   1                 asynchronous, active-low reset
// - in_valid     in   PORT_NUM          per-port beat valid
// - in_ready     out  PORT_NUM          per-port beat accept
// - in_payload   in   PORT_NUM*PLD_W    per-port payload, port i at [i*PLD_W +: PLD_W]
// - in_srcid     in   PORT_NUM*ID_W     per-port srcid
// - in_tgtid     in   PORT_NUM*ID_W     per-port tgtid
// - in_qos       in   PORT_NUM          per-port priority (1 = high); sampled on first beat only
// - in_last      in   PORT_NUM          per-port last beat of packet
// - out_valid    out  1                 NoC req valid
// - out_ready    in   1                 NoC req ready
// - out_payload  out  PLD_W             granted payload
// - out_srcid    out  ID_W              granted srcid
// - out_tgtid    out  ID_W              granted tgtid
// - out_qos      out  1                 granted qos
// - out_last     out  1                 granted last
// - hold_req     in   1                 stop starting new packets
// - hold_ack     out  1                 no packet in flight, output buffer empty
// - busy         out  1                 packet locked or output buffer non-empty
// BEHAVIOUR
// - Reset: state ARB_IDLE, rr_ptr=0, starve_cnt=0, lock_idx=0, buffer empty;
//   out_valid=0, in_ready=0, busy=0; hold_ack=hold_req.
// - Output path through 2-entry skid buffer: accepted input beat appears on out_* next cycle;
//   full throughput 1 beat/cycle; buffer space (sb_rdy) = fewer than 2 entries, or 1 entry being popped.
// - FSM ARB_IDLE:
//   - No grant if hold_req=1 or no in_valid.
//   - Candidate class: valid ports with in_qos=1; if starve_cnt==STARVE_LIMIT and any valid qos=0 port,
//     class = valid qos=0 ports; if no qos=1 port valid, class = all valid ports.
//   - Winner = first port in class at or after rr_ptr (circular); in_ready[winner]=sb_rdy, others 0.
//   - On first-beat accept: rr_ptr <= (winner+1) mod PORT_NUM; in_last=1 stays ARB_IDLE,
//     else lock_idx <= winner and go ARB_LOCKED.
// - FSM ARB_LOCKED:
//   - in_ready[lock_idx]=sb_rdy, all others 0; hold_req ignored.
//   - Locked port dropping in_valid mid-packet: wait, no other port granted.
//   - Accepted beat with in_last=1: back to ARB_IDLE; new grant possible the next cycle.
// - starve_cnt, updated on each first-beat accept:
//   - qos=1 winner while any qos=0 port valid: +1, saturating at STARVE_LIMIT.
//   - qos=0 winner: cleared to 0.
//   - otherwise unchanged.
// - hold_req:
//   - Asserted mid-packet: packet completes, then no new grant.
//   - hold_ack = hold_req & state==ARB_IDLE & buffer empty (combinational).
//   - Deassert resumes arbitration the same cycle.
// - busy = (state==ARB_LOCKED) | buffer non-empty.
// - out_valid held until out_ready; out_* stable while out_valid & !out_ready.
// - Async reset mid-packet: everything returns to reset values; partial beats are dropped.
//   Sources are reset alongside.
// STRUCTURE
// - dti_pack additions:
//   - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e
//   - typedef struct packed {payload; srcid; tgtid; qos; last} dti_req_beat_t (widths from pack constants)
// - Sub-module dti_skid_buf: 2-entry valid/ready buffer of dti_req_beat_t.
// - Arbiter FSM, rr pointer, starve counter and in_ready decode stay in this module.
// TESTING
// - Single port 0, 3-beat packet qos=1, out_ready=1 -> beats on out_* at cycles 1..3, srcid/last intact,
//   busy=0 after the last beat drains.
// - Ports 0..3 all valid, 1-beat qos=1 packets, 8 packets -> grant order 0,1,2,3,0,1,2,3;
//   no idle cycles on out_valid.
// - Port 1 mid 4-beat packet stalls valid 5 cycles while port 2 is valid -> no port-2 beat until port-1 last;
//   port 2 granted next.
// - Ports 0,1 continuous qos=1, port 3 qos=0 valid, STARVE_LIMIT=8 -> port 3 granted as the 9th packet;
//   starve_cnt returns to 0.
// - hold_req raised during beat 2 of a 4-beat packet, out_ready toggling -> packet finishes; hold_ack=1
//   once the buffer empties; no new in_ready while held.
// - out_ready=0 for 10 cycles with 3 ports valid -> at most 2 beats accepted; out_* stable;
//   assert rst_n=0 mid-packet -> out_valid=0, in_ready=0 immediately.

Source files
------------

// File: rtl/dti_req_arbiter_pkg.sv
// Shared types for the DTI request-channel arbiter.
//   arb_state_e     : arbiter FSM state (idle / locked on a multi-beat packet)
//   dti_req_beat_t  : one request beat as carried on the custom NoC channel
//   DTI_PLD_W/ID_W  : default payload ({tdata[79:0], tkeep[9:0]}) and id widths
package dti_req_arbiter_pkg;

   localparam int unsigned DTI_PLD_W = 90;
   localparam int unsigned DTI_ID_W  = 6;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_e;

   typedef struct packed {
      logic [DTI_PLD_W-1:0] payload;
      logic [DTI_ID_W-1:0]  srcid;
      logic [DTI_ID_W-1:0]  tgtid;
      logic                 qos;
      logic                 last;
   } dti_req_beat_t;

endpackage

// File: rtl/dti_skid_buf.sv
// Two-entry valid/ready buffer between the arbiter and the NoC request channel.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     write side; in_ready = space for a beat this cycle
//   in_beat               beat to store
//   out_valid/out_ready   read side; out_beat held stable until popped
//   out_beat              oldest stored beat
//   empty                 no beat stored
module dti_skid_buf
   import dti_req_arbiter_pkg::*;
#(
   parameter type beat_t = dti_req_beat_t
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  in_valid,
   output logic  in_ready,
   input  beat_t in_beat,
   output logic  out_valid,
   input  logic  out_ready,
   output beat_t out_beat,
   output logic  empty
);

   beat_t      mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       push;
   logic       pop;

   assign out_valid = (count != 2'd0);
   assign empty     = (count == 2'd0);
   assign pop       = out_valid & out_ready;
   // Full buffer still accepts when the head leaves in the same cycle.
   assign in_ready  = (count != 2'd2) | pop;
   assign push      = in_valid & in_ready;
   assign out_beat  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_beat;
   end

endmodule

// File: rtl/dti_req_arbiter.sv
// Packet-level arbiter sharing one NoC request channel between PORT_NUM DTI sources.
// QoS-aware round robin with a starvation guard for qos=0 ports; a granted packet
// keeps the channel until its last beat. hold_req/hold_ack drain at a packet boundary.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_last        per-port beat handshake and end of packet
//   in_payload/in_srcid/in_tgtid     per-port beat fields, port i at [i*W +: W]
//   in_qos                           per-port priority (1 = high), taken from first beat
//   out_valid/out_ready/out_*        granted beat stream towards the NoC
//   hold_req/hold_ack                stop new packets / channel drained and idle
//   busy                             packet locked or output buffer occupied
module dti_req_arbiter
   import dti_req_arbiter_pkg::*;
#(
   parameter int unsigned PORT_NUM     = 4,
   parameter int unsigned PLD_W        = DTI_PLD_W,
   parameter int unsigned ID_W         = DTI_ID_W,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [PORT_NUM-1:0]      in_valid,
   output logic [PORT_NUM-1:0]      in_ready,
   input  logic [PORT_NUM*PLD_W-1:0] in_payload,
   input  logic [PORT_NUM*ID_W-1:0] in_srcid,
   input  logic [PORT_NUM*ID_W-1:0] in_tgtid,
   input  logic [PORT_NUM-1:0]      in_qos,
   input  logic [PORT_NUM-1:0]      in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PLD_W-1:0]         out_payload,
   output logic [ID_W-1:0]          out_srcid,
   output logic [ID_W-1:0]          out_tgtid,
   output logic                     out_qos,
   output logic                     out_last,
   input  logic                     hold_req,
   output logic                     hold_ack,
   output logic                     busy
);

   localparam int unsigned IDX_W = $clog2(PORT_NUM);

   // Same layout as dti_req_beat_t, sized by this instance's parameters.
   typedef struct packed {
      logic [PLD_W-1:0] payload;
      logic [ID_W-1:0]  srcid;
      logic [ID_W-1:0]  tgtid;
      logic             qos;
      logic             last;
   } beat_t;

   arb_state_e          state, state_next;
   logic [IDX_W-1:0]    rr_ptr, rr_next;
   logic [IDX_W-1:0]    lock_idx, lock_next;
   logic [7:0]          starve_cnt, starve_next;
   logic                pkt_qos, pkt_qos_next;
   logic [PORT_NUM-1:0] hi_v, lo_v, cls;
   logic [IDX_W-1:0]    winner, sel;
   logic                found;
   int unsigned         scan_idx;
   logic                sb_rdy, sb_empty, sb_in_valid;
   beat_t               sb_in, sb_out;

   // Candidate class and circular first-match from rr_ptr.
   always_comb begin
      hi_v     = in_valid & in_qos;
      lo_v     = in_valid & ~in_qos;
      winner   = '0;
      found    = 1'b0;
      scan_idx = 0;
      if (hi_v == '0)
         cls = in_valid;
      else if (starve_cnt == 8'(STARVE_LIMIT) && lo_v != '0)
         cls = lo_v;
      else
         cls = hi_v;
      for (int unsigned i = 0; i < PORT_NUM; i++) begin
         scan_idx = (32'(rr_ptr) + i) % PORT_NUM;
         if (!found && cls[scan_idx]) begin
            found  = 1'b1;
            winner = IDX_W'(scan_idx);
         end
      end
   end

   always_comb begin
      state_next   = state;
      rr_next      = rr_ptr;
      lock_next    = lock_idx;
      starve_next  = starve_cnt;
      pkt_qos_next = pkt_qos;
      in_ready     = '0;
      sel          = winner;
      sb_in_valid  = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (!hold_req && found) begin
               in_ready[winner] = sb_rdy;
               sb_in_valid      = 1'b1;
               if (sb_rdy) begin
                  rr_next      = IDX_W'((32'(winner) + 32'd1) % PORT_NUM);
                  pkt_qos_next = in_qos[winner];
                  if (!in_qos[winner])
                     starve_next = '0;
                  else if (lo_v != '0 && starve_cnt != 8'(STARVE_LIMIT))
                     starve_next = starve_cnt + 8'd1;
                  if (!in_last[winner]) begin
                     lock_next  = winner;
                     state_next = ARB_LOCKED;
                  end
               end
            end
         end
         ARB_LOCKED: begin
            sel                = lock_idx;
            in_ready[lock_idx] = sb_rdy;
            sb_in_valid        = in_valid[lock_idx];
            if (in_valid[lock_idx] && sb_rdy && in_last[lock_idx])
               state_next = ARB_IDLE;
         end
         default: state_next = ARB_IDLE;
      endcase
      // Keep sources stalled while reset is asserted, not only after the first edge.
      if (!rst_n) in_ready = '0;
   end

   // Beat mux; later beats of a packet carry the qos seen on its first beat.
   always_comb begin
      sb_in = '0;
      for (int unsigned i = 0; i < PORT_NUM; i++) begin
         if (IDX_W'(i) == sel) begin
            sb_in.payload = in_payload[i*PLD_W +: PLD_W];
            sb_in.srcid   = in_srcid[i*ID_W +: ID_W];
            sb_in.tgtid   = in_tgtid[i*ID_W +: ID_W];
            sb_in.qos     = (state == ARB_LOCKED) ? pkt_qos : in_qos[i];
            sb_in.last    = in_last[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         rr_ptr     <= '0;
         lock_idx   <= '0;
         starve_cnt <= '0;
         pkt_qos    <= 1'b0;
      end else begin
         state      <= state_next;
         rr_ptr     <= rr_next;
         lock_idx   <= lock_next;
         starve_cnt <= starve_next;
         pkt_qos    <= pkt_qos_next;
      end
   end

   dti_skid_buf #(.beat_t(beat_t)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sb_in_valid),
      .in_ready  (sb_rdy),
      .in_beat   (sb_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_beat  (sb_out),
      .empty     (sb_empty)
   );

   assign out_payload = sb_out.payload;
   assign out_srcid   = sb_out.srcid;
   assign out_tgtid   = sb_out.tgtid;
   assign out_qos     = sb_out.qos;
   assign out_last    = sb_out.last;
   assign hold_ack    = hold_req & (state == ARB_IDLE) & sb_empty;
   assign busy        = (state == ARB_LOCKED) | ~sb_empty;

endmodule

// File: tb/tb_dti_req_arbiter.sv
// Self-checking bench for dti_req_arbiter: per-port source queues drive packets,
// an expected-beat queue is popped and compared on every output handshake.
module tb_dti_req_arbiter;

   localparam int NP = 4;
   localparam int PW = 90;
   localparam int IW = 6;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NP-1:0]    in_valid;
   logic [NP-1:0]    in_ready;
   logic [NP*PW-1:0] in_payload;
   logic [NP*IW-1:0] in_srcid;
   logic [NP*IW-1:0] in_tgtid;
   logic [NP-1:0]    in_qos;
   logic [NP-1:0]    in_last;
   logic             out_valid;
   logic             out_ready;
   logic [PW-1:0]    out_payload;
   logic [IW-1:0]    out_srcid;
   logic [IW-1:0]    out_tgtid;
   logic             out_qos;
   logic             out_last;
   logic             hold_req;
   logic             hold_ack;
   logic             busy;

   dti_req_arbiter #(.PORT_NUM(NP), .PLD_W(PW), .ID_W(IW), .STARVE_LIMIT(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_payload  (in_payload),
      .in_srcid    (in_srcid),
      .in_tgtid    (in_tgtid),
      .in_qos      (in_qos),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (out_payload),
      .out_srcid   (out_srcid),
      .out_tgtid   (out_tgtid),
      .out_qos     (out_qos),
      .out_last    (out_last),
      .hold_req    (hold_req),
      .hold_ack    (hold_ack),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic          bubble;
      logic [PW-1:0] payload;
      logic [IW-1:0] srcid;
      logic [IW-1:0] tgtid;
      logic          qos;
      logic          last;
   } tb_beat_t;

   tb_beat_t      src_q [NP][$];
   tb_beat_t      exp_q [$];
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [NP-1:0] acc;
   int            first_out, last_out, out_cnt;

   function automatic tb_beat_t mk(int p, int pk, int b, logic qos, logic last);
      tb_beat_t t;
      t.bubble  = 1'b0;
      t.payload = (90'(p) << 80) | (90'(pk) << 40) | (90'(b) << 8) | 90'(8'h5A);
      t.srcid   = 6'(p + 8);
      t.tgtid   = 6'(pk * 4 + b + 1);
      t.qos     = qos;
      t.last    = last;
      return t;
   endfunction

   function automatic bit src_busy();
      for (int p = 0; p < NP; p++)
         if (src_q[p].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   // Source packet, optionally with stall_len idle cycles before beat stall_at.
   task automatic add_pkt(int p, int pk, int n, logic qos, int stall_at, int stall_len);
      tb_beat_t gap;
      gap = '0;
      gap.bubble = 1'b1;
      for (int b = 0; b < n; b++) begin
         if (b == stall_at)
            for (int k = 0; k < stall_len; k++) src_q[p].push_back(gap);
         src_q[p].push_back(mk(p, pk, b, qos, b == n - 1));
      end
   endtask

   task automatic expect_pkt(int p, int pk, int n, logic qos);
      for (int b = 0; b < n; b++) exp_q.push_back(mk(p, pk, b, qos, b == n - 1));
   endtask

   task automatic drive_inputs();
      tb_beat_t t;
      for (int p = 0; p < NP; p++) begin
         if (src_q[p].size() > 0 && !src_q[p][0].bubble) begin
            t = src_q[p][0];
            in_valid[p]              = 1'b1;
            in_payload[p*PW +: PW]   = t.payload;
            in_srcid[p*IW +: IW]     = t.srcid;
            in_tgtid[p*IW +: IW]     = t.tgtid;
            in_qos[p]                = t.qos;
            in_last[p]               = t.last;
         end else begin
            in_valid[p] = 1'b0;
         end
      end
   endtask

   // One clock: sample handshakes on negedge, score output beat, advance sources.
   task automatic cycle();
      tb_beat_t e;
      @(negedge clk);
      acc = in_valid & in_ready;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected: got srcid %h payload %h, want no beat", out_srcid, out_payload);
         end else begin
            e = exp_q.pop_front();
            if ({out_payload, out_srcid, out_tgtid, out_qos, out_last} !==
                {e.payload, e.srcid, e.tgtid, e.qos, e.last}) begin
               n_fail++;
               $display("FAIL out_beat: got %h/%h/%h/%b/%b, want %h/%h/%h/%b/%b",
                        out_payload, out_srcid, out_tgtid, out_qos, out_last,
                        e.payload, e.srcid, e.tgtid, e.qos, e.last);
            end
         end
         if (first_out < 0) first_out = cyc;
         last_out = cyc;
         out_cnt++;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++)
         if (src_q[p].size() > 0 && (acc[p] || src_q[p][0].bubble))
            void'(src_q[p].pop_front());
      drive_inputs();
   endtask

   task automatic run_until_done(int budget, string name);
      int k;
      k = 0;
      while ((exp_q.size() > 0 || src_busy()) && k < budget) begin
         cycle();
         k++;
      end
      n_tests++;
      if (exp_q.size() != 0 || src_busy()) begin
         n_fail++;
         $display("FAIL %s_timeout: got %0d beats outstanding after %0d cycles, want 0", name, exp_q.size(), budget);
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      hold_req   = 1'b0;
      out_ready  = 1'b1;
      in_valid   = '0;
      in_qos     = '0;
      in_last    = '0;
      in_payload = '0;
      in_srcid   = '0;
      in_tgtid   = '0;
      for (int p = 0; p < NP; p++) src_q[p].delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      first_out = -1;
      last_out  = -1;
      out_cnt   = 0;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n    = 1'b0;
      in_valid = '1;
      #1;
      n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b, want 0000", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, want 0", busy); end
      n_tests++; if (hold_ack !== 1'b0) begin n_fail++; $display("FAIL reset_hold_ack_lo: got %b, want 0", hold_ack); end
      hold_req = 1'b1;
      #1;
      n_tests++; if (hold_ack !== 1'b1) begin n_fail++; $display("FAIL reset_hold_ack_hi: got %b, want 1", hold_ack); end
      hold_req = 1'b0;
      in_valid = '0;
   endtask

   task automatic test_single();
      int c0;
      do_reset();
      c0 = cyc;
      add_pkt(0, 0, 3, 1'b1, -1, 0);
      expect_pkt(0, 0, 3, 1'b1);
      drive_inputs();
      run_until_done(20, "single");
      n_tests++; if (first_out != c0 + 1) begin n_fail++; $display("FAIL single_first_cycle: got %0d, want %0d", first_out - c0, 1); end
      n_tests++; if (last_out != c0 + 3) begin n_fail++; $display("FAIL single_last_cycle: got %0d, want %0d", last_out - c0, 3); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drained: got %b, want 0", busy); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int pk = 0; pk < 2; pk++)
         for (int p = 0; p < NP; p++) begin
            add_pkt(p, pk, 1, 1'b1, -1, 0);
            expect_pkt(p, pk, 1, 1'b1);
         end
      drive_inputs();
      run_until_done(30, "rr");
      n_tests++; if (out_cnt != 8) begin n_fail++; $display("FAIL rr_count: got %0d, want 8", out_cnt); end
      n_tests++; if (last_out - first_out != 7) begin n_fail++; $display("FAIL rr_no_idle: got span %0d, want 7", last_out - first_out); end
   endtask

   task automatic test_lock_stall();
      do_reset();
      add_pkt(1, 0, 4, 1'b1, 2, 5);
      add_pkt(2, 0, 2, 1'b1, -1, 0);
      expect_pkt(1, 0, 4, 1'b1);
      expect_pkt(2, 0, 2, 1'b1);
      drive_inputs();
      run_until_done(40, "lock_stall");
   endtask

   task automatic test_starvation();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         add_pkt(0, k, 1, 1'b1, -1, 0);
         add_pkt(1, k, 1, 1'b1, -1, 0);
      end
      add_pkt(3, 0, 1, 1'b0, -1, 0);
      for (int k = 0; k < 4; k++) begin
         expect_pkt(0, k, 1, 1'b1);
         expect_pkt(1, k, 1, 1'b1);
      end
      expect_pkt(3, 0, 1, 1'b0);
      for (int k = 4; k < 6; k++) begin
         expect_pkt(0, k, 1, 1'b1);
         expect_pkt(1, k, 1, 1'b1);
      end
      drive_inputs();
      run_until_done(40, "starve");
      n_tests++; if (dut.starve_cnt !== 8'd0) begin n_fail++; $display("FAIL starve_cnt_clear: got %0d, want 0", dut.starve_cnt); end
   endtask

   task automatic test_hold();
      int viol;
      viol = 0;
      do_reset();
      add_pkt(0, 0, 4, 1'b1, -1, 0);
      add_pkt(1, 0, 1, 1'b1, -1, 0);
      expect_pkt(0, 0, 4, 1'b1);
      drive_inputs();
      for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
         out_ready = (k % 2 == 0);
         if (src_q[0].size() <= 2) hold_req = 1'b1;
         cycle();
         if (hold_req && acc[1]) viol++;
      end
      out_ready = 1'b1;
      for (int k = 0; k < 10 && hold_ack !== 1'b1; k++) begin
         cycle();
         if (acc[1]) viol++;
      end
      n_tests++; if (hold_ack !== 1'b1) begin n_fail++; $display("FAIL hold_ack: got %b, want 1", hold_ack); end
      n_tests++; if (viol != 0) begin n_fail++; $display("FAIL hold_no_grant: got %0d grants while held, want 0", viol); end
      n_tests++; if (src_q[1].size() != 1) begin n_fail++; $display("FAIL hold_port1_waiting: got %0d beats left, want 1", src_q[1].size()); end
      hold_req = 1'b0;
      #1;
      n_tests++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL hold_resume: got in_ready %b, want 0010", in_ready); end
      expect_pkt(1, 0, 1, 1'b1);
      run_until_done(20, "hold_resume");
   endtask

   task automatic test_backpressure_reset();
      tb_beat_t snap, want;
      bit       have_snap;
      int       accepted, unstable;
      have_snap = 1'b0;
      accepted  = 0;
      unstable  = 0;
      snap      = '0;
      do_reset();
      out_ready = 1'b0;
      for (int p = 0; p < 3; p++) add_pkt(p, 0, 4, 1'b1, -1, 0);
      drive_inputs();
      for (int k = 0; k < 10; k++) begin
         cycle();
         accepted += $countones(acc);
         if (have_snap) begin
            if (out_valid !== 1'b1 ||
                {out_payload, out_srcid, out_tgtid, out_qos, out_last} !==
                {snap.payload, snap.srcid, snap.tgtid, snap.qos, snap.last}) unstable++;
         end else if (out_valid === 1'b1) begin
            have_snap = 1'b1;
            snap = '0;
            snap.payload = out_payload;
            snap.srcid   = out_srcid;
            snap.tgtid   = out_tgtid;
            snap.qos     = out_qos;
            snap.last    = out_last;
         end
      end
      want = mk(0, 0, 0, 1'b1, 1'b0);
      n_tests++; if (accepted > 2) begin n_fail++; $display("FAIL bp_accepted: got %0d beats, want at most 2", accepted); end
      n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changed cycles, want 0", unstable); end
      n_tests++; if ({snap.payload, snap.srcid, snap.last} !== {want.payload, want.srcid, want.last}) begin
         n_fail++; $display("FAIL bp_head_beat: got %h/%h/%b, want %h/%h/%b", snap.payload, snap.srcid, snap.last, want.payload, want.srcid, want.last);
      end
      rst_n = 1'b0;
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b, want 0", out_valid); end
      n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL midreset_in_ready: got %b, want 0000", in_ready); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b, want 0", busy); end
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_lock_stall();
      test_starvation();
      test_hold();
      test_backpressure_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
